pipeline_sink: RTL and testbench
================================

PIPELINE_SINK -- requirements
Module: pipeline_sink

Interface
REQ-001 Parameter DATA_W, default 32, width of pipeline data and drain data.
REQ-002 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pipe_data  in  DATA_W  data from the last pipeline stage.
REQ-007 pipe_valid  in  1  last stage holds a valid word.
REQ-008 pipe_flush  in  1  last stage carries a flush marker.
REQ-009 ext_stall  in  1  external stall request, OR'd into global_stall.
REQ-010 global_stall  out  1  stall broadcast to every pipeline stage.
REQ-011 m_data  out  DATA_W  drain data, head of FIFO.
REQ-012 m_valid  out  1  FIFO non-empty.
REQ-013 m_ready  in  1  drain consumer accepts m_data.
REQ-014 level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 accept_cnt, flush_cnt, stall_cnt  out  CNT_W each  words accepted / flushes seen / stalled cycles.

Function
REQ-016 global_stall SHALL be combinational: (level == DEPTH) OR ext_stall; a pop in the same cycle SHALL NOT lower it.
REQ-017 "Sample cycle" = cycle with global_stall low; pipe_* SHALL be ignored in every other cycle, so a stalled, held word is never captured twice.
REQ-018 Sample cycle with pipe_flush=1: FIFO SHALL be emptied (level=0 next cycle), pipe_valid/pipe_data ignored, flush_cnt incremented.
REQ-019 Sample cycle with pipe_flush=0 and pipe_valid=1: pipe_data SHALL be pushed; accept_cnt incremented.
REQ-020 Pop SHALL occur when m_valid and m_ready are both 1; m_data SHALL show the oldest entry, zero latency from the head pointer.
REQ-021 Pop without flush in the same cycle SHALL complete normally; pop with flush SHALL count as taken and the FIFO SHALL be empty afterwards.
REQ-022 Simultaneous push and pop SHALL leave level unchanged and preserve order.
REQ-023 Word latency: captured at edge N, visible on m_data/m_valid after edge N if the FIFO was empty.
REQ-024 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.
REQ-025 stall_cnt SHALL increment on every cycle global_stall is 1.
REQ-026 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 m_data SHALL be 0 when m_valid is 0.

Reset
REQ-028 On reset: level=0, m_valid=0, m_data=0, all counters 0, pointers 0; global_stall then equals ext_stall.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents and counter values, with no pop reported that cycle.

Structure
REQ-030 DATA_W, DEPTH, CNT_W defaults and a shared saturating-increment function SHALL live in package pipeline_pkg.
REQ-031 Storage SHALL be one sub-module, sync_fifo (push, pop, clear, data, level); stall, flush, and counter logic SHALL stay in pipeline_sink.

Verification
REQ-032 Reset, then push 0x11,0x22,0x33 with m_ready=0 -> level=3, m_data=0x11, accept_cnt=3, global_stall=0.
REQ-033 Push 8 words with m_ready=0 -> global_stall=1 after 8th; pipe_valid held with 0xAA for 5 cycles -> level stays 8, accept_cnt=8, stall_cnt=5; raise m_ready 1 cycle -> 0xAA captured exactly once.
REQ-034 Level 4, pipe_flush=1 and m_ready=1 same cycle -> level=0 next cycle, flush_cnt=1, one pop.
REQ-035 ext_stall=1 for 3 cycles with pipe_valid=1 pipe_data=0x5 -> no capture, stall_cnt=3; release -> single capture of 0x5.
REQ-036 Continuous push and pop 20 cycles at level 1 -> level remains 1, output order equals input order, pointers wrap cleanly.
REQ-037 Assert reset at level 5 mid-stream -> level=0, m_valid=0, all counters 0 next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline sink block:
//   - default widths / depth used as parameter defaults
//   - sample-cycle classification used by the sink control logic
//   - statistics counter indices
//   - sat_inc(): width-generic saturating increment used by every counter
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;
    localparam int CNT_W_DEF  = 16;

    // What the sink does with the last pipeline stage in the current cycle.
    typedef enum logic [1:0] {
        SAMPLE_IDLE  = 2'd0,   // sample cycle, nothing valid
        SAMPLE_PUSH  = 2'd1,   // sample cycle, word captured
        SAMPLE_FLUSH = 2'd2,   // sample cycle, flush marker seen
        SAMPLE_STALL = 2'd3    // not a sample cycle, pipe_* ignored
    } sample_op_e;

    localparam int CNT_ACCEPT = 0;
    localparam int CNT_FLUSH  = 1;
    localparam int CNT_STALL  = 2;
    localparam int NUM_CNT    = 3;

    // Saturating increment for a counter of 'width' bits carried in 64 bits.
    // Callers cast the result back to their own counter width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with zero-latency head read (rd_data always shows the
// entry at the read pointer) and a synchronous clear that empties it.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, wr_data       write wr_data when not full
//   pop                 drop the head entry when not empty
//   clear               empty the FIFO; wins over push and pop
//   rd_data             head entry (raw storage, not qualified by level)
//   level               occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic do_push;
    logic do_pop;

    // Guard against overflow/underflow locally so level stays in 0..DEPTH
    // no matter what the requester does.
    assign do_push = push && (level_q != LVL_W'(DEPTH)) && !clear;
    assign do_pop  = pop  && (level_q != '0)            && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the level counter decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/pipeline_sink.sv
// -----------------------------------------------------------------------------
// pipeline_sink
// Terminates a stalling pipeline: captures words from the last stage into a
// FIFO, drains them over a valid/ready port, broadcasts a global stall when
// the FIFO is full (or on external request) and keeps saturating statistics.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   pipe_data/valid/flush         last pipeline stage
//   ext_stall                     external stall request
//   global_stall                  combinational stall broadcast
//   m_data/m_valid/m_ready        drain port (m_data is 0 when empty)
//   level                         FIFO occupancy
//   accept_cnt/flush_cnt/stall_cnt saturating statistics counters
// -----------------------------------------------------------------------------
module pipeline_sink
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              pipe_valid,
    input  logic              pipe_flush,
    input  logic              ext_stall,
    output logic              global_stall,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  accept_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [LVL_W-1:0]  fifo_level;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic              fifo_full;
    sample_op_e        sample_op;
    logic [NUM_CNT-1:0] cnt_inc;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clear   (fifo_clear),
        .wr_data (pipe_data),
        .rd_data (fifo_rd_data),
        .level   (fifo_level)
    );

    // Full is taken from the registered level, so a pop in this cycle does
    // not release the stall until the next cycle. That keeps a held word from
    // being captured in the same cycle the consumer frees a slot.
    assign fifo_full    = (fifo_level == LVL_W'(DEPTH));
    assign global_stall = fifo_full || ext_stall;

    always_comb begin
        sample_op = SAMPLE_IDLE;
        if (global_stall) begin
            sample_op = SAMPLE_STALL;
        end else if (pipe_flush) begin
            sample_op = SAMPLE_FLUSH;
        end else if (pipe_valid) begin
            sample_op = SAMPLE_PUSH;
        end
    end

    assign m_valid    = (fifo_level != '0);
    assign m_data     = m_valid ? fifo_rd_data : '0;
    // A pop coinciding with a flush is still handed to the consumer; the
    // clear then empties whatever remains.
    assign fifo_pop   = m_valid && m_ready;
    assign fifo_push  = (sample_op == SAMPLE_PUSH);
    assign fifo_clear = (sample_op == SAMPLE_FLUSH);

    always_comb begin
        cnt_inc             = '0;
        cnt_inc[CNT_ACCEPT] = (sample_op == SAMPLE_PUSH);
        cnt_inc[CNT_FLUSH]  = (sample_op == SAMPLE_FLUSH);
        cnt_inc[CNT_STALL]  = global_stall;
    end

    // One saturating counter per statistic.
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_inc[gi]) begin
                cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_W));
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign accept_cnt = g_cnt[CNT_ACCEPT].cnt_q;
    assign flush_cnt  = g_cnt[CNT_FLUSH].cnt_q;
    assign stall_cnt  = g_cnt[CNT_STALL].cnt_q;
    assign level      = fifo_level;

endmodule

// File: tb/tb_pipeline_sink.sv
module tb_pipeline_sink;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic [DW-1:0] pipe_data;
    logic          pipe_valid;
    logic          pipe_flush;
    logic          ext_stall;
    logic          global_stall;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
    logic [CW-1:0] accept_cnt;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] stall_cnt;

    pipeline_sink #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_data    (pipe_data),
        .pipe_valid   (pipe_valid),
        .pipe_flush   (pipe_flush),
        .ext_stall    (ext_stall),
        .global_stall (global_stall),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .accept_cnt   (accept_cnt),
        .flush_cnt    (flush_cnt),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    // Reference model: FIFO contents as a queue, counters as plain ints.
    logic [DW-1:0] mq[$];
    int            m_acc = 0;
    int            m_fl  = 0;
    int            m_st  = 0;
    logic [DW-1:0] popped[$];
    logic [DW-1:0] sent[$];

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic compare_all();
        logic [DW-1:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : '0;
        check_val("level",        64'(level),        64'(mq.size()));
        check_val("m_valid",      64'(m_valid),      64'(mq.size() != 0));
        check_val("m_data",       64'(m_data),       64'(exp_data));
        check_val("global_stall", 64'(global_stall), 64'((mq.size() == DEPTH) || ext_stall));
        check_val("accept_cnt",   64'(accept_cnt),   64'(m_acc));
        check_val("flush_cnt",    64'(flush_cnt),    64'(m_fl));
        check_val("stall_cnt",    64'(stall_cnt),    64'(m_st));
    endtask

    task automatic model_step();
        bit stall, pop;
        if (reset) begin
            mq.delete();
            m_acc = 0;
            m_fl  = 0;
            m_st  = 0;
            return;
        end
        stall = (mq.size() == DEPTH) || ext_stall;
        pop   = (mq.size() != 0) && m_ready;
        if (stall) m_st = sat(m_st);
        if (!stall && pipe_flush) begin
            mq.delete();
            m_fl = sat(m_fl);
        end else begin
            if (pop) void'(mq.pop_front());
            if (!stall && pipe_valid) begin
                mq.push_back(pipe_data);
                m_acc = sat(m_acc);
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        if (!reset && m_valid && m_ready) popped.push_back(m_data);
        $display("cyc %0d rst=%0b v=%0b f=%0b es=%0b rdy=%0b d=0x%0h | lvl=%0d gs=%0b mv=%0b md=0x%0h",
                 n_cyc, reset, pipe_valid, pipe_flush, ext_stall, m_ready, pipe_data,
                 level, global_stall, m_valid, m_data);
        model_step();
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pipe_valid = 1'b0;
        pipe_flush = 1'b0;
        ext_stall  = 1'b0;
        m_ready    = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int aa_seen;
        reset      = 1'b1;
        pipe_data  = '0;
        pipe_valid = 1'b0;
        pipe_flush = 1'b0;
        ext_stall  = 1'b0;
        m_ready    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check_val("rst_level",  64'(level),   64'd0);
        check_val("rst_mvalid", 64'(m_valid), 64'd0);
        check_val("rst_mdata",  64'(m_data),  64'd0);
        check_val("rst_gs",     64'(global_stall), 64'd0);
        check_val("rst_acc",    64'(accept_cnt), 64'd0);

        // Three pushes, no drain
        foreach (sent[i]) ;
        pipe_valid = 1'b1;
        pipe_data = 32'h11; cyc();
        pipe_data = 32'h22; cyc();
        pipe_data = 32'h33; cyc();
        pipe_valid = 1'b0;
        check_val("p3_level", 64'(level), 64'd3);
        check_val("p3_mdata", 64'(m_data), 64'h11);
        check_val("p3_acc",   64'(accept_cnt), 64'd3);
        check_val("p3_gs",    64'(global_stall), 64'd0);

        // Fill to full, hold a word under stall, release one slot
        do_reset();
        pipe_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pipe_data = 32'(i + 1);
            cyc();
        end
        check_val("full_gs", 64'(global_stall), 64'd1);
        pipe_data = 32'hAA;
        repeat (5) cyc();
        check_val("hold_level", 64'(level), 64'd8);
        check_val("hold_acc",   64'(accept_cnt), 64'd8);
        check_val("hold_stall", 64'(stall_cnt), 64'd5);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        cyc();
        pipe_valid = 1'b0;
        check_val("aa_level", 64'(level), 64'd8);
        check_val("aa_acc",   64'(accept_cnt), 64'd9);
        popped.delete();
        m_ready = 1'b1;
        repeat (10) cyc();
        m_ready = 1'b0;
        aa_seen = 0;
        foreach (popped[i]) if (popped[i] == 32'hAA) aa_seen++;
        check_val("aa_once",  64'(aa_seen), 64'd1);
        check_val("aa_drain", 64'(popped.size()), 64'd8);

        // Flush at level 4 with a simultaneous pop
        do_reset();
        pipe_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pipe_data = $urandom;
            cyc();
        end
        pipe_valid = 1'b0;
        popped.delete();
        pipe_flush = 1'b1;
        m_ready    = 1'b1;
        cyc();
        pipe_flush = 1'b0;
        m_ready    = 1'b0;
        check_val("fl_level", 64'(level), 64'd0);
        check_val("fl_cnt",   64'(flush_cnt), 64'd1);
        check_val("fl_pops",  64'(popped.size()), 64'd1);

        // External stall holds a word off for three cycles
        do_reset();
        ext_stall  = 1'b1;
        pipe_valid = 1'b1;
        pipe_data  = 32'h5;
        repeat (3) cyc();
        check_val("es_level", 64'(level), 64'd0);
        check_val("es_stall", 64'(stall_cnt), 64'd3);
        ext_stall = 1'b0;
        cyc();
        pipe_valid = 1'b0;
        check_val("es_level1", 64'(level), 64'd1);
        check_val("es_acc",    64'(accept_cnt), 64'd1);
        check_val("es_mdata",  64'(m_data), 64'h5);

        // Streaming push+pop at level 1, pointers wrap several times
        popped.delete();
        sent.delete();
        sent.push_back(32'h5);
        m_ready    = 1'b1;
        pipe_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pipe_data = $urandom;
            sent.push_back(pipe_data);
            cyc();
            check_val("st_level", 64'(level), 64'd1);
        end
        pipe_valid = 1'b0;
        m_ready    = 1'b0;
        for (int i = 0; i < 20; i++)
            check_val("st_order", 64'(popped[i]), 64'(sent[i]));

        // Reset in mid-stream at level 5
        do_reset();
        pipe_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pipe_data = $urandom;
            cyc();
        end
        check_val("mr_level5", 64'(level), 64'd5);
        reset   = 1'b1;
        m_ready = 1'b1;
        cyc();
        reset      = 1'b0;
        pipe_valid = 1'b0;
        m_ready    = 1'b0;
        check_val("mr_level",  64'(level), 64'd0);
        check_val("mr_mvalid", 64'(m_valid), 64'd0);
        check_val("mr_acc",    64'(accept_cnt), 64'd0);
        check_val("mr_flush",  64'(flush_cnt), 64'd0);
        check_val("mr_stall",  64'(stall_cnt), 64'd0);

        // Randomized traffic, including counter saturation
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            pipe_valid = ($urandom_range(0, 9) < 7);
            pipe_flush = ($urandom_range(0, 19) == 0);
            ext_stall  = ($urandom_range(0, 9) == 0);
            m_ready    = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 7));
            pipe_data  = $urandom;
            cyc();
        end
        reset = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
